// File: rtl/kbd_bcd_entry.sv
// Keypad-style decimal entry from PS/2 set-2 make codes into 3-digit BCD with a valid/ready hold.
// Optional feature: define KBD_BACKSPACE_EN to enable Backspace (0x66) editing while entering.
module kbd_bcd_entry #(
    parameter int unsigned MAX_VALUE = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [9:0] bcd,
    output logic       bcd_valid,
    input  logic       bcd_ready,
    output logic [1:0] digit_cnt,
    output logic       err
);

    localparam int unsigned DIG_W = 4;
    localparam int unsigned VAL_W = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIG_W-1:0]   r_hund, r_tens, r_ones;
    logic [DIG_W-1:0]   w_hund_nxt, w_tens_nxt, w_ones_nxt;
    logic [1:0]         r_cnt, w_cnt_nxt;
    logic               r_err, w_err_nxt;
    logic               r_valid, w_valid_nxt;

    logic               w_is_digit;
    logic [DIG_W-1:0]   w_digit;
    logic               w_key_digit, w_key_enter, w_key_esc;
    logic [VAL_W-1:0]   w_value;
    logic               w_over;
`ifdef KBD_BACKSPACE_EN
    logic               w_key_bksp;
`endif

    // Set-2 make code to decimal digit
    always_comb begin
        w_is_digit = 1'b1;
        w_digit    = 4'd0;
        case (scan_code)
            8'h45:   w_digit = 4'd0;
            8'h16:   w_digit = 4'd1;
            8'h1E:   w_digit = 4'd2;
            8'h26:   w_digit = 4'd3;
            8'h25:   w_digit = 4'd4;
            8'h2E:   w_digit = 4'd5;
            8'h36:   w_digit = 4'd6;
            8'h3D:   w_digit = 4'd7;
            8'h3E:   w_digit = 4'd8;
            8'h46:   w_digit = 4'd9;
            default: w_is_digit = 1'b0;
        endcase
    end

    assign w_key_digit = scan_valid && w_is_digit;
    assign w_key_enter = scan_valid && (scan_code == 8'h5A);
    assign w_key_esc   = scan_valid && (scan_code == 8'h76);
`ifdef KBD_BACKSPACE_EN
    assign w_key_bksp  = scan_valid && (scan_code == 8'h66);
`endif

    // Hundreds is kept at full BCD width so 3xx..9xx can be detected and rejected
    assign w_value = VAL_W'(r_hund) * VAL_W'(100) + VAL_W'(r_tens) * VAL_W'(10) + VAL_W'(r_ones);
    assign w_over  = 32'(w_value) > MAX_VALUE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hund  <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hund  <= w_hund_nxt;
            r_tens  <= w_tens_nxt;
            r_ones  <= w_ones_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_key_digit) w_state_nxt = S_ENTRY;
            end
            S_ENTRY: begin
                if (w_key_enter)    w_state_nxt = w_over ? S_IDLE : S_HOLD;
                else if (w_key_esc) w_state_nxt = S_IDLE;
`ifdef KBD_BACKSPACE_EN
                else if (w_key_bksp && (r_cnt == 2'd1)) w_state_nxt = S_IDLE;
`endif
            end
            S_HOLD: begin
                if (bcd_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Digit datapath and registered output next-values
    always_comb begin
        w_hund_nxt  = r_hund;
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_valid_nxt = (w_state_nxt == S_HOLD);
        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (w_key_digit && (r_cnt != 2'd3)) begin
                    w_hund_nxt = r_tens;
                    w_tens_nxt = r_ones;
                    w_ones_nxt = w_digit;
                    w_cnt_nxt  = r_cnt + 2'd1;
                end else if ((r_state == S_ENTRY) && (w_key_enter || w_key_esc)) begin
                    if (w_key_esc || w_over) begin
                        w_hund_nxt = '0;
                        w_tens_nxt = '0;
                        w_ones_nxt = '0;
                        w_cnt_nxt  = '0;
                        w_err_nxt  = w_key_enter;
                    end
                end
`ifdef KBD_BACKSPACE_EN
                else if ((r_state == S_ENTRY) && w_key_bksp) begin
                    w_ones_nxt = r_tens;
                    w_tens_nxt = r_hund;
                    w_hund_nxt = '0;
                    w_cnt_nxt  = r_cnt - 2'd1;
                end
`endif
            end
            S_HOLD: begin
                if (bcd_ready) begin
                    w_hund_nxt = '0;
                    w_tens_nxt = '0;
                    w_ones_nxt = '0;
                    w_cnt_nxt  = '0;
                end
            end
            default: begin
                w_hund_nxt = '0;
                w_tens_nxt = '0;
                w_ones_nxt = '0;
                w_cnt_nxt  = '0;
            end
        endcase
    end

    assign bcd       = {r_hund[1:0], r_tens, r_ones};
    assign bcd_valid = r_valid;
    assign digit_cnt = r_cnt;
    assign err       = r_err;

endmodule

// File: tb/tb_kbd_bcd_entry.sv
// Directed bench for kbd_bcd_entry; expectations follow KBD_BACKSPACE_EN when the bench is built with it.
module tb_kbd_bcd_entry;

    logic       clk;
    logic       rst_n;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [9:0] bcd;
    logic       bcd_valid;
    logic       bcd_ready;
    logic [1:0] digit_cnt;
    logic       err;

    int n_checks;
    int n_fails;

    localparam logic [7:0] K0 = 8'h45, K1 = 8'h16, K2 = 8'h1E, K3 = 8'h26, K4 = 8'h25;
    localparam logic [7:0] K5 = 8'h2E, K6 = 8'h36, K7 = 8'h3D, K8 = 8'h3E, K9 = 8'h46;
    localparam logic [7:0] KENT = 8'h5A, KBKSP = 8'h66, KESC = 8'h76;

    kbd_bcd_entry #(.MAX_VALUE(255)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .bcd        (bcd),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .digit_cnt  (digit_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle strobe; returns at the following falling edge with the result registered
    task automatic press(input logic [7:0] code);
        @(negedge clk);
        scan_code  = code;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic release_hold();
        @(negedge clk);
        bcd_ready = 1'b1;
        @(negedge clk);
        bcd_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bcd !== 10'd0 || bcd_valid !== 1'b0 || digit_cnt !== 2'd0 || err !== 1'b0) begin
            n_fails++;
            $display("FAIL reset: bcd=%b valid=%b cnt=%0d err=%b, need all 0", bcd, bcd_valid, digit_cnt, err);
        end
    endtask

    task automatic test_accept_255();
        press(K2);
        n_checks++;
        if (digit_cnt !== 2'd1 || bcd !== 10'b00_0000_0010) begin
            n_fails++;
            $display("FAIL acc_first_digit: cnt=%0d bcd=%b, need 1 / 0000000010", digit_cnt, bcd);
        end
        press(K5);
        press(K5);
        n_checks++;
        if (digit_cnt !== 2'd3 || bcd !== 10'b10_0101_0101 || bcd_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL acc_digits: cnt=%0d bcd=%b valid=%b, need 3 / 1001010101 / 0", digit_cnt, bcd, bcd_valid);
        end
        press(KENT);
        n_checks++;
        if (bcd_valid !== 1'b1 || err !== 1'b0 || bcd !== 10'b10_0101_0101) begin
            n_fails++;
            $display("FAIL acc_enter: valid=%b err=%b bcd=%b, need 1 / 0 / 1001010101", bcd_valid, err, bcd);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (bcd_valid !== 1'b1 || bcd !== 10'b10_0101_0101) begin
            n_fails++;
            $display("FAIL acc_held: valid=%b bcd=%b, need 1 / 1001010101", bcd_valid, bcd);
        end
        release_hold();
        n_checks++;
        if (bcd_valid !== 1'b0 || bcd !== 10'd0 || digit_cnt !== 2'd0) begin
            n_fails++;
            $display("FAIL acc_release: valid=%b bcd=%b cnt=%0d, need 0 / 0 / 0", bcd_valid, bcd, digit_cnt);
        end
    endtask

    task automatic test_reject(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input string nm);
        press(a);
        press(b);
        press(c);
        press(KENT);
        n_checks++;
        if (err !== 1'b1 || bcd_valid !== 1'b0 || bcd !== 10'd0 || digit_cnt !== 2'd0) begin
            n_fails++;
            $display("FAIL %s_enter: err=%b valid=%b bcd=%b cnt=%0d, need 1 / 0 / 0 / 0", nm, err, bcd_valid, bcd, digit_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || bcd_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL %s_pulse: err=%b valid=%b, need 0 / 0", nm, err, bcd_valid);
        end
    endtask

    task automatic test_fourth_digit();
        press(K1);
        press(K9);
        press(K7);
        press(K4);
        n_checks++;
        if (digit_cnt !== 2'd3 || bcd !== 10'b01_1001_0111) begin
            n_fails++;
            $display("FAIL fourth_ignored: cnt=%0d bcd=%b, need 3 / 0110010111", digit_cnt, bcd);
        end
        press(KENT);
        n_checks++;
        if (bcd_valid !== 1'b1 || err !== 1'b0 || bcd !== 10'b01_1001_0111) begin
            n_fails++;
            $display("FAIL fourth_enter: valid=%b err=%b bcd=%b, need 1 / 0 / 0110010111", bcd_valid, err, bcd);
        end
        release_hold();
    endtask

    task automatic test_backspace();
        press(K6);
        press(K4);
        press(K9);
        press(KBKSP);
`ifdef KBD_BACKSPACE_EN
        n_checks++;
        if (digit_cnt !== 2'd2 || bcd !== 10'b00_0110_0100) begin
            n_fails++;
            $display("FAIL bksp_edit: cnt=%0d bcd=%b, need 2 / 0001100100", digit_cnt, bcd);
        end
        press(KENT);
        n_checks++;
        if (bcd_valid !== 1'b1 || err !== 1'b0 || bcd !== 10'b00_0110_0100) begin
            n_fails++;
            $display("FAIL bksp_enter: valid=%b err=%b bcd=%b, need 1 / 0 / 0001100100", bcd_valid, err, bcd);
        end
        release_hold();
`else
        n_checks++;
        if (digit_cnt !== 2'd3 || bcd !== 10'b10_0100_1001) begin
            n_fails++;
            $display("FAIL bksp_ignored: cnt=%0d bcd=%b, need 3 / 1001001001", digit_cnt, bcd);
        end
        press(KENT);
        n_checks++;
        if (err !== 1'b1 || bcd_valid !== 1'b0 || bcd !== 10'd0 || digit_cnt !== 2'd0) begin
            n_fails++;
            $display("FAIL bksp_reject: err=%b valid=%b bcd=%b cnt=%0d, need 1 / 0 / 0 / 0", err, bcd_valid, bcd, digit_cnt);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_hold_drop();
        press(K1);
        press(KENT);
        n_checks++;
        if (bcd_valid !== 1'b1 || bcd !== 10'b00_0000_0001) begin
            n_fails++;
            $display("FAIL hold_accept: valid=%b bcd=%b, need 1 / 0000000001", bcd_valid, bcd);
        end
        @(negedge clk);
        scan_code  = K7;
        scan_valid = 1'b1;
        bcd_ready  = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        bcd_ready  = 1'b0;
        n_checks++;
        if (bcd_valid !== 1'b0 || digit_cnt !== 2'd0 || bcd !== 10'd0) begin
            n_fails++;
            $display("FAIL hold_drop: valid=%b cnt=%0d bcd=%b, need 0 / 0 / 0", bcd_valid, digit_cnt, bcd);
        end
        @(negedge clk);
        n_checks++;
        if (digit_cnt !== 2'd0 || bcd !== 10'd0) begin
            n_fails++;
            $display("FAIL hold_drop_late: cnt=%0d bcd=%b, need 0 / 0", digit_cnt, bcd);
        end
    endtask

    task automatic test_reset_mid_entry();
        press(K4);
        press(K2);
        n_checks++;
        if (digit_cnt !== 2'd2 || bcd !== 10'b00_0100_0010) begin
            n_fails++;
            $display("FAIL rstmid_pre: cnt=%0d bcd=%b, need 2 / 0001000010", digit_cnt, bcd);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bcd !== 10'd0 || bcd_valid !== 1'b0 || digit_cnt !== 2'd0 || err !== 1'b0) begin
            n_fails++;
            $display("FAIL rstmid_async: bcd=%b valid=%b cnt=%0d err=%b, need all 0", bcd, bcd_valid, digit_cnt, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        press(KENT);
        n_checks++;
        if (bcd_valid !== 1'b0 || err !== 1'b0 || digit_cnt !== 2'd0 || bcd !== 10'd0) begin
            n_fails++;
            $display("FAIL rstmid_enter: valid=%b err=%b cnt=%0d bcd=%b, need 0 / 0 / 0 / 0", bcd_valid, err, digit_cnt, bcd);
        end
    endtask

    task automatic test_esc_and_ignored();
        press(8'h1C);
        press(KBKSP);
        press(KENT);
        n_checks++;
        if (digit_cnt !== 2'd0 || bcd_valid !== 1'b0 || err !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_ignore: cnt=%0d valid=%b err=%b, need 0 / 0 / 0", digit_cnt, bcd_valid, err);
        end
        press(K8);
        press(K3);
        press(KESC);
        n_checks++;
        if (digit_cnt !== 2'd0 || bcd !== 10'd0 || err !== 1'b0 || bcd_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL esc_clear: cnt=%0d bcd=%b err=%b valid=%b, need 0 / 0 / 0 / 0", digit_cnt, bcd, err, bcd_valid);
        end
    endtask

    task automatic test_zero_entry();
        press(K0);
        n_checks++;
        if (digit_cnt !== 2'd1 || bcd !== 10'd0) begin
            n_fails++;
            $display("FAIL zero_digit: cnt=%0d bcd=%b, need 1 / 0", digit_cnt, bcd);
        end
        press(KENT);
        n_checks++;
        if (bcd_valid !== 1'b1 || err !== 1'b0 || bcd !== 10'd0) begin
            n_fails++;
            $display("FAIL zero_enter: valid=%b err=%b bcd=%b, need 1 / 0 / 0", bcd_valid, err, bcd);
        end
        release_hold();
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst_n      = 1'b0;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        bcd_ready  = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_accept_255();
        test_reject(K3, K0, K0, "rej300");
        test_reject(K2, K5, K6, "rej256");
        test_fourth_digit();
        test_backspace();
        test_hold_drop();
        test_reset_mid_entry();
        test_esc_and_ignored();
        test_zero_entry();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
